wb_write_sequencer: RTL and testbench
=====================================

// Module: wb_write_sequencer
// PURPOSE
//  Parametrised, registered successor to the 4-to-16 decoder: turns up to two register-file write requests per
//  instruction (e.g. load result Rd + base writeback Rn) into one-hot write enables for a single-write-port register file.
//  Serialises dual writes over two cycles, detects same-address and out-of-range requests; sits between writeback and regfile.
// PARAMETERS
//  ADDR_W   4            width of each write address
//  NUM_OUT  2**ADDR_W    number of decoded enable lines (<= 2**ADDR_W); addresses >= NUM_OUT are out of range
//  CNT_W    8            collision counter width (only with WB_COLL_CNT_EN)
// PORTS
//  clk         in   1        clock; all state on rising edge
//  reset       in   1        asynchronous, active-high reset
//  ENABLE      in   1        global enable; low = stall (see BEHAVIOUR)
//  in_valid    in   1        request pair valid
//  in_ready    out  1        pair accepted when in_valid & in_ready
//  wr_en0      in   1        port-0 request (priority port)
//  wr_addr0    in   ADDR_W   port-0 address
//  wr_en1      in   1        port-1 request
//  wr_addr1    in   ADDR_W   port-1 address
//  we_onehot   out  NUM_OUT  registered one-hot write enable (all zero when we_valid=0)
//  we_valid    out  1        we_onehot carries a write this cycle
//  we_src      out  1        0 = write data from port 0, 1 = from port 1
//  collision   out  1        1-cycle pulse: same-address pair accepted
//  oor         out  1        1-cycle pulse: an enabled address >= NUM_OUT was dropped
//  coll_sticky out  1        set by collision, cleared by clr_sticky
//  clr_sticky  in   1        clears coll_sticky (set wins if same cycle)
//  coll_count  out  CNT_W    saturating collision count (only with WB_COLL_CNT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, we_onehot=0, we_valid=0, we_src=0, collision=0, oor=0, coll_sticky=0, coll_count=0; pending pair discarded.
//  in_ready = ENABLE & (state==IDLE), combinational from state.
//  FSM IDLE: on accept, in cycle N+1 drive the first valid write (port 0 if wr_en0 & in-range, else port 1 if valid).
//    both valid, addr0!=addr1 -> port0 at N+1, latch addr1, go REPLAY; port1 at N+2 (we_src=1), back to IDLE.
//    both valid, addr0==addr1 -> port0 only at N+1, collision=1 at N+1, coll_sticky set, stay IDLE.
//    neither valid (both disabled and/or out of range) -> we_valid=0 at N+1.
//  FSM REPLAY: issue latched port-1 write, return to IDLE; in_ready=0 throughout.
//  Out-of-range enabled request: dropped, oor=1 in N+1; does not count as collision; its partner proceeds normally.
//  Latency: 1 cycle accept->enable; dual pair occupies 2 cycles; max throughput 1 write/cycle.
//  ENABLE low: no accept, FSM and latched addr1 hold, outputs we_valid/we_onehot/collision/oor go 0 next cycle;
//    REPLAY resumes the cycle after ENABLE returns high.
//  Non-accept cycles in IDLE: we_valid=0, we_onehot=0. At most one bit of we_onehot high, ever.
// CONFIGURATION
//  WB_COLL_CNT_EN defined: coll_count port present, +1 per collision pulse, saturates at 2**CNT_W-1, reset to 0.
//  Undefined: coll_count port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package wb_decode_pkg: state encoding localparams (IDLE, REPLAY), in-range check function.
//  Sub-module onehot_decode #(ADDR_W,NUM_OUT): combinational, enable-gated address->one-hot, zero if disabled or
//  out of range; instanced once on the muxed (port0 / latched port1) address ahead of the output register.
// TESTING (ADDR_W=4, NUM_OUT=16)
//  Reset held with pending REPLAY -> all outputs 0, in_ready=1 after release, no stale port-1 write.
//  en0=1 a0=3, en1=0 -> N+1 we_onehot=0x0008, we_src=0, in_ready stays 1.
//  en0=1 a0=2, en1=1 a1=13 -> N+1 0x0004 src0, N+2 0x2000 src1, in_ready=0 during N+1.
//  en0=en1=1, a0=a1=5 -> N+1 0x0020 src0, collision=1, coll_sticky=1; coll_count=1 with WB_COLL_CNT_EN.
//  NUM_OUT=15: en0=1 a0=15, en1=1 a1=4 -> N+1 0x0010 src1, oor=1, no REPLAY.
//  ENABLE low in REPLAY for 3 cycles -> port-1 write delayed until cycle after ENABLE high, appears exactly once.

Source files
------------

// File: rtl/wb_decode_pkg.sv
// Shared types and helpers for the writeback write sequencer: FSM state encoding
// and the address range check used by the sequencer and its decoder.
package wb_decode_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      REPLAY = 1'b1
   } state_t;

   function automatic logic in_range(input logic [31:0] addr, input int unsigned num_out);
      return addr < num_out;
   endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational enable-gated address to one-hot decoder; output is all zero when
// disabled or when the address lies outside the NUM_OUT decoded lines.
module onehot_decode
   import wb_decode_pkg::*;
#(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned NUM_OUT = 2**ADDR_W
) (
   input  logic               en,
   input  logic [ADDR_W-1:0]  addr,
   output logic [NUM_OUT-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en && in_range(32'(addr), NUM_OUT)) begin
         for (int unsigned i = 0; i < NUM_OUT; i++) begin
            onehot[i] = (32'(addr) == i);
         end
      end
   end

endmodule

// File: rtl/wb_write_sequencer.sv
// Serialises up to two register-file write requests into registered one-hot enables
// for a single write port. Optional collision counter enabled by WB_COLL_CNT_EN.
module wb_write_sequencer
   import wb_decode_pkg::*;
#(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned NUM_OUT = 2**ADDR_W
`ifdef WB_COLL_CNT_EN
   ,
   parameter int unsigned CNT_W   = 8
`endif
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ENABLE,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               wr_en0,
   input  logic [ADDR_W-1:0]  wr_addr0,
   input  logic               wr_en1,
   input  logic [ADDR_W-1:0]  wr_addr1,
   output logic [NUM_OUT-1:0] we_onehot,
   output logic               we_valid,
   output logic               we_src,
   output logic               collision,
   output logic               oor,
   output logic               coll_sticky,
   input  logic               clr_sticky
`ifdef WB_COLL_CNT_EN
   ,
   output logic [CNT_W-1:0]   coll_count
`endif
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr1_q, addr1_d;
   logic                dec_en, dec_src, collision_d, oor_d;
   logic [ADDR_W-1:0]   dec_addr;
   logic [NUM_OUT-1:0]  dec_onehot;
   logic                v0, v1, accept;

   assign in_ready = ENABLE & (state_q == IDLE);
   assign accept   = in_valid & in_ready;
   assign v0       = wr_en0 & in_range(32'(wr_addr0), NUM_OUT);
   assign v1       = wr_en1 & in_range(32'(wr_addr1), NUM_OUT);

   // ENABLE low leaves state and latched addr1 untouched and issues nothing.
   always_comb begin
      state_d     = state_q;
      addr1_d     = addr1_q;
      dec_en      = 1'b0;
      dec_addr    = wr_addr0;
      dec_src     = 1'b0;
      collision_d = 1'b0;
      oor_d       = 1'b0;
      if (ENABLE) begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  oor_d = (wr_en0 & ~v0) | (wr_en1 & ~v1);
                  if (v0) begin
                     dec_en = 1'b1;
                     if (v1) begin
                        if (wr_addr0 == wr_addr1) begin
                           collision_d = 1'b1;
                        end else begin
                           addr1_d = wr_addr1;
                           state_d = REPLAY;
                        end
                     end
                  end else if (v1) begin
                     dec_en   = 1'b1;
                     dec_addr = wr_addr1;
                     dec_src  = 1'b1;
                  end
               end
            end
            REPLAY: begin
               dec_en   = 1'b1;
               dec_addr = addr1_q;
               dec_src  = 1'b1;
               state_d  = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   onehot_decode #(
      .ADDR_W  (ADDR_W),
      .NUM_OUT (NUM_OUT)
   ) u_decode (
      .en     (dec_en),
      .addr   (dec_addr),
      .onehot (dec_onehot)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         addr1_q     <= '0;
         we_onehot   <= '0;
         we_valid    <= 1'b0;
         we_src      <= 1'b0;
         collision   <= 1'b0;
         oor         <= 1'b0;
         coll_sticky <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr1_q     <= addr1_d;
         we_onehot   <= dec_onehot;
         we_valid    <= dec_en;
         we_src      <= dec_src;
         collision   <= collision_d;
         oor         <= oor_d;
         if (collision_d) begin
            coll_sticky <= 1'b1;
         end else if (clr_sticky) begin
            coll_sticky <= 1'b0;
         end
      end
   end

`ifdef WB_COLL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         coll_count <= '0;
      end else if (collision_d && (coll_count != '1)) begin
         coll_count <= coll_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed self-checking bench for wb_write_sequencer (16-line and 15-line builds).
// Honours WB_COLL_CNT_EN for the collision counter checks.
module tb_wb_write_sequencer;

   logic        clk = 1'b0;
   logic        reset, ENABLE, in_valid, wr_en0, wr_en1, clr_sticky;
   logic [3:0]  wr_addr0, wr_addr1;
   logic        in_ready, we_valid, we_src, collision, oor, coll_sticky;
   logic [15:0] we_onehot;
   logic        in_ready15, we_valid15, we_src15, collision15, oor15, coll_sticky15;
   logic [14:0] we_onehot15;
`ifdef WB_COLL_CNT_EN
   logic [7:0]  coll_count, coll_count15;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_write_sequencer #(.ADDR_W(4), .NUM_OUT(16)) dut (
      .clk(clk), .reset(reset), .ENABLE(ENABLE), .in_valid(in_valid), .in_ready(in_ready),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_en1(wr_en1), .wr_addr1(wr_addr1),
      .we_onehot(we_onehot), .we_valid(we_valid), .we_src(we_src), .collision(collision),
      .oor(oor), .coll_sticky(coll_sticky), .clr_sticky(clr_sticky)
`ifdef WB_COLL_CNT_EN
      , .coll_count(coll_count)
`endif
   );

   wb_write_sequencer #(.ADDR_W(4), .NUM_OUT(15)) dut15 (
      .clk(clk), .reset(reset), .ENABLE(ENABLE), .in_valid(in_valid), .in_ready(in_ready15),
      .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_en1(wr_en1), .wr_addr1(wr_addr1),
      .we_onehot(we_onehot15), .we_valid(we_valid15), .we_src(we_src15),
      .collision(collision15), .oor(oor15), .coll_sticky(coll_sticky15), .clr_sticky(clr_sticky)
`ifdef WB_COLL_CNT_EN
      , .coll_count(coll_count15)
`endif
   );

   task automatic drive(input logic v, input logic e0, input logic [3:0] a0,
                        input logic e1, input logic [3:0] a1);
      in_valid = v; wr_en0 = e0; wr_addr0 = a0; wr_en1 = e1; wr_addr1 = a1;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++;
      if ({we_valid, we_onehot, we_src, collision, oor, coll_sticky} !== 21'h0) begin
         errors++; $display("FAIL reset_outputs got %h exp 0",
            {we_valid, we_onehot, we_src, collision, oor, coll_sticky});
      end
      reset = 1'b0;
      drive(1'b1, 1'b1, 4'd2, 1'b1, 4'd13);
      @(negedge clk);
      checks++;
      if (we_onehot !== 16'h0004) begin
         errors++; $display("FAIL reset_pre_first got %h exp 0004", we_onehot);
      end
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      reset = 1'b1;
      #1;
      checks++;
      if (we_valid !== 1'b0 || we_onehot !== 16'h0) begin
         errors++; $display("FAIL reset_async got valid=%b oh=%h exp 0/0000", we_valid, we_onehot);
      end
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b exp 1", in_ready);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (we_valid !== 1'b0 || we_onehot !== 16'h0) begin
            errors++; $display("FAIL reset_stale got valid=%b oh=%h exp 0/0000", we_valid, we_onehot);
         end
      end
   endtask

   task automatic test_single;
      drive(1'b1, 1'b1, 4'd3, 1'b0, 4'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      checks++;
      if ({we_valid, we_onehot, we_src, in_ready} !== {1'b1, 16'h0008, 1'b0, 1'b1}) begin
         errors++; $display("FAIL single got v=%b oh=%h src=%b rdy=%b exp 1/0008/0/1",
            we_valid, we_onehot, we_src, in_ready);
      end
      @(negedge clk);
      checks++;
      if (we_valid !== 1'b0 || we_onehot !== 16'h0) begin
         errors++; $display("FAIL single_idle got v=%b oh=%h exp 0/0000", we_valid, we_onehot);
      end
   endtask

   task automatic test_dual;
      drive(1'b1, 1'b1, 4'd2, 1'b1, 4'd13);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      checks++;
      if ({we_valid, we_onehot, we_src, in_ready} !== {1'b1, 16'h0004, 1'b0, 1'b0}) begin
         errors++; $display("FAIL dual_first got v=%b oh=%h src=%b rdy=%b exp 1/0004/0/0",
            we_valid, we_onehot, we_src, in_ready);
      end
      @(negedge clk);
      checks++;
      if ({we_valid, we_onehot, we_src, in_ready} !== {1'b1, 16'h2000, 1'b1, 1'b1}) begin
         errors++; $display("FAIL dual_second got v=%b oh=%h src=%b rdy=%b exp 1/2000/1/1",
            we_valid, we_onehot, we_src, in_ready);
      end
      @(negedge clk);
      checks++;
      if (we_valid !== 1'b0) begin
         errors++; $display("FAIL dual_idle got %b exp 0", we_valid);
      end
   endtask

   task automatic test_collision;
      drive(1'b1, 1'b1, 4'd5, 1'b1, 4'd5);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      checks++;
      if ({we_valid, we_onehot, we_src, collision, coll_sticky, in_ready}
          !== {1'b1, 16'h0020, 1'b0, 1'b1, 1'b1, 1'b1}) begin
         errors++; $display("FAIL coll_first got v=%b oh=%h src=%b c=%b s=%b rdy=%b exp 1/0020/0/1/1/1",
            we_valid, we_onehot, we_src, collision, coll_sticky, in_ready);
      end
`ifdef WB_COLL_CNT_EN
      checks++;
      if (coll_count !== 8'd1) begin
         errors++; $display("FAIL coll_count1 got %0d exp 1", coll_count);
      end
`endif
      @(negedge clk);
      checks++;
      if ({we_valid, collision, coll_sticky} !== 3'b001) begin
         errors++; $display("FAIL coll_after got v=%b c=%b s=%b exp 0/0/1",
            we_valid, collision, coll_sticky);
      end
      clr_sticky = 1'b1;
      @(negedge clk);
      clr_sticky = 1'b0;
      checks++;
      if (coll_sticky !== 1'b0) begin
         errors++; $display("FAIL coll_clear got %b exp 0", coll_sticky);
      end
      // Set and clear in the same cycle: set must win.
      drive(1'b1, 1'b1, 4'd9, 1'b1, 4'd9);
      clr_sticky = 1'b1;
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      clr_sticky = 1'b0;
      checks++;
      if ({collision, coll_sticky, we_onehot} !== {1'b1, 1'b1, 16'h0200}) begin
         errors++; $display("FAIL coll_setwins got c=%b s=%b oh=%h exp 1/1/0200",
            collision, coll_sticky, we_onehot);
      end
`ifdef WB_COLL_CNT_EN
      checks++;
      if (coll_count !== 8'd2) begin
         errors++; $display("FAIL coll_count2 got %0d exp 2", coll_count);
      end
`endif
      clr_sticky = 1'b1;
      @(negedge clk);
      clr_sticky = 1'b0;
   endtask

   task automatic test_oor;
      drive(1'b1, 1'b1, 4'd15, 1'b1, 4'd4);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      checks++;
      if ({we_valid15, we_onehot15, we_src15, oor15, collision15, in_ready15}
          !== {1'b1, 15'h0010, 1'b1, 1'b1, 1'b0, 1'b1}) begin
         errors++; $display("FAIL oor_partner got v=%b oh=%h src=%b oor=%b c=%b rdy=%b exp 1/0010/1/1/0/1",
            we_valid15, we_onehot15, we_src15, oor15, collision15, in_ready15);
      end
      @(negedge clk);
      checks++;
      if ({we_valid15, oor15} !== 2'b00) begin
         errors++; $display("FAIL oor_noreplay got v=%b oor=%b exp 0/0", we_valid15, oor15);
      end
      @(negedge clk);
      drive(1'b1, 1'b1, 4'd15, 1'b0, 4'd0);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      checks++;
      if ({we_valid15, we_onehot15, oor15} !== {1'b1 ^ 1'b1, 15'h0, 1'b1}) begin
         errors++; $display("FAIL oor_only got v=%b oh=%h oor=%b exp 0/0000/1",
            we_valid15, we_onehot15, oor15);
      end
      drive(1'b1, 1'b0, 4'd3, 1'b0, 4'd7);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      checks++;
      if ({we_valid, oor, we_onehot} !== {1'b0, 1'b0, 16'h0}) begin
         errors++; $display("FAIL none_enabled got v=%b oor=%b oh=%h exp 0/0/0000",
            we_valid, oor, we_onehot);
      end
   endtask

   task automatic test_stall;
      drive(1'b1, 1'b1, 4'd1, 1'b1, 4'd9);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      ENABLE = 1'b0;
      checks++;
      if (we_onehot !== 16'h0002) begin
         errors++; $display("FAIL stall_first got %h exp 0002", we_onehot);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({we_valid, we_onehot, in_ready} !== {1'b0, 16'h0, 1'b0}) begin
            errors++; $display("FAIL stall_hold%0d got v=%b oh=%h rdy=%b exp 0/0000/0",
               i, we_valid, we_onehot, in_ready);
         end
      end
      ENABLE = 1'b1;
      @(negedge clk);
      checks++;
      if ({we_valid, we_onehot, we_src} !== {1'b1, 16'h0200, 1'b1}) begin
         errors++; $display("FAIL stall_resume got v=%b oh=%h src=%b exp 1/0200/1",
            we_valid, we_onehot, we_src);
      end
      @(negedge clk);
      checks++;
      if (we_valid !== 1'b0) begin
         errors++; $display("FAIL stall_once got %b exp 0", we_valid);
      end
      // ENABLE low in IDLE refuses a pair outright.
      ENABLE = 1'b0;
      drive(1'b1, 1'b1, 4'd6, 1'b0, 4'd0);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL stall_ready got %b exp 0", in_ready);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      ENABLE = 1'b1;
      checks++;
      if (we_valid !== 1'b0) begin
         errors++; $display("FAIL stall_noaccept got %b exp 0", we_valid);
      end
   endtask

   initial begin
      reset = 1'b1; ENABLE = 1'b1; clr_sticky = 1'b0;
      drive(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
      test_reset;
      test_single;
      test_dual;
      test_collision;
      test_oor;
      test_stall;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
